maximo_ventana: RTL and testbench

Windowed maximum finder feeding the 3-bit greater-than comparator path. It accepts a stream of unsigned samples over a valid/ready handshake and keeps the running maximum with a strict "D > MAX" comparison, the same relation the `mayor` comparator implements. After every N accepted samples it presents the window maximum and its position, and holds them until the consumer takes them. This is the sequential stage that produces the operands the comparator stage consumes.

---
 rtl/maximo_ventana_if.sv | 19 +
 rtl/maximo_ventana.sv | 86 ++++++++
 tb/tb_maximo_ventana.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/maximo_ventana_if.sv
// Sample stream in, windowed-maximum result out. The producer/consumer side
// takes master; the windowed-max block takes slave.
interface maximo_ventana_if #(
  parameter int W = 3,
  parameter int N = 8
);
  localparam int IW = $clog2(N);

  logic [W-1:0]  D;
  logic          D_valid;
  logic          D_ready;
  logic [W-1:0]  MAX;
  logic [IW-1:0] IDX;
  logic          F_valid;
  logic          F_ready;

  modport master (output D, D_valid, F_ready, input D_ready, MAX, IDX, F_valid);
  modport slave  (input D, D_valid, F_ready, output D_ready, MAX, IDX, F_valid);
endinterface

// File: rtl/maximo_ventana.sv
// Windowed maximum over N accepted samples. The earliest maximum wins because
// the compare is strict; the result is held until the consumer takes it.
module maximo_ventana #(
  parameter int W = 3,
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  maximo_ventana_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic {CAPTURA, RESULTADO} estado_t;

  estado_t       estado_q, estado_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  max_q, max_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          f_valid_q, f_valid_d;
  logic          d_ready;
  logic          accept;

  // Ready is decoded from state alone so D_valid never reaches an output.
  assign d_ready = (estado_q == CAPTURA);
  assign accept  = bus.D_valid && d_ready;

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    idx_d     = idx_q;
    f_valid_d = f_valid_q;
    case (estado_q)
      CAPTURA: begin
        if (accept) begin
          if (cnt_q == '0) begin
            max_d = bus.D;
            idx_d = '0;
          end else if (bus.D > max_q) begin
            max_d = bus.D;
            idx_d = cnt_q;
          end
          if (cnt_q == LAST) begin
            cnt_d     = '0;
            estado_d  = RESULTADO;
            f_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESULTADO: begin
        if (bus.F_ready) begin
          estado_d  = CAPTURA;
          f_valid_d = 1'b0;
        end
      end
      default: begin
        estado_d  = CAPTURA;
        f_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= CAPTURA;
      cnt_q     <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      f_valid_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      f_valid_q <= f_valid_d;
    end
  end

  assign bus.D_ready = d_ready;
  assign bus.MAX     = max_q;
  assign bus.IDX     = idx_q;
  assign bus.F_valid = f_valid_q;
endmodule

// File: tb/tb_maximo_ventana.sv
// Bench for maximo_ventana: a queue-based window model checked every cycle,
// plus literal expectations for each directed window.
module tb_maximo_ventana;
  localparam int W = 3;
  localparam int N = 8;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  maximo_ventana_if #(.W(W), .N(N)) bus ();

  maximo_ventana #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: collect accepted samples, and on the Nth scan for the first maximum.
  logic [W-1:0] win[$];
  bit           exp_fv = 0;
  int           exp_max = 0;
  int           exp_idx = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win.delete();
      exp_fv = 0;
    end else if (exp_fv) begin
      if (bus.F_ready === 1'b1) exp_fv = 0;
    end else if (bus.D_valid === 1'b1) begin
      win.push_back(bus.D);
      if (win.size() == N) begin
        exp_max = win[0];
        exp_idx = 0;
        for (int i = 1; i < N; i++)
          if (int'(win[i]) > exp_max) begin
            exp_max = win[i];
            exp_idx = i;
          end
        exp_fv = 1;
        win.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_F_valid", int'(bus.F_valid), int'(exp_fv));
      chk("model_D_ready", int'(bus.D_ready), int'(!exp_fv));
      if (exp_fv) begin
        chk("model_MAX", int'(bus.MAX), exp_max);
        chk("model_IDX", int'(bus.IDX), exp_idx);
      end
    end
  end

  logic [W-1:0] w [N];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drives the first n entries of w, with gap idle cycles between samples.
  task automatic send(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.D = w[i];
      bus.D_valid = 1'b1;
      step();
      if (i != n - 1)
        for (int g = 0; g < gap; g++) begin
          bus.D_valid = 1'b0;
          step();
        end
    end
    bus.D_valid = 1'b0;
  endtask

  task automatic chk_result(input string name, input int mx, input int ix);
    chk({name, "_F_valid"}, int'(bus.F_valid), 1);
    chk({name, "_D_ready"}, int'(bus.D_ready), 0);
    chk({name, "_MAX"}, int'(bus.MAX), mx);
    chk({name, "_IDX"}, int'(bus.IDX), ix);
  endtask

  initial begin
    bus.D = '0;
    bus.D_valid = 1'b0;
    bus.F_ready = 1'b1;

    // Reset with the clock stopped
    #20;
    chk("rst_MAX", int'(bus.MAX), 0);
    chk("rst_IDX", int'(bus.IDX), 0);
    chk("rst_F_valid", int'(bus.F_valid), 0);
    chk("rst_D_ready", int'(bus.D_ready), 1);
    clk_en = 1'b1;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_F_valid", int'(bus.F_valid), 0);
      chk("idle_D_ready", int'(bus.D_ready), 1);
      chk("idle_MAX", int'(bus.MAX), 0);
    end

    // Basic window: one-cycle result pulse
    w = '{3'd1, 3'd5, 3'd3, 3'd7, 3'd2, 3'd0, 3'd6, 3'd4};
    send(N, 0);
    chk_result("basic", 7, 3);
    step();
    chk("basic_pulse_end", int'(bus.F_valid), 0);
    chk("basic_ready_back", int'(bus.D_ready), 1);

    // Ties keep the earliest index
    w = '{3'd4, 3'd6, 3'd6, 3'd2, 3'd6, 3'd1, 3'd0, 3'd3};
    send(N, 0);
    chk_result("ties", 6, 1);
    step();

    w = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    send(N, 0);
    chk_result("zeros", 0, 0);
    step();

    // Back-pressure: held result, extra samples ignored
    bus.F_ready = 1'b0;
    w = '{3'd7, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    send(N, 0);
    chk_result("bp", 7, 0);
    bus.D = 3'd3;
    bus.D_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_result("bp_hold", 7, 0);
    end
    bus.F_ready = 1'b1;
    step();
    chk("bp_handoff_F_valid", int'(bus.F_valid), 0);
    chk("bp_handoff_D_ready", int'(bus.D_ready), 1);
    w = '{3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    send(N, 0);
    chk_result("bp_next", 2, 0);
    step();

    // Gapped input
    w = '{3'd1, 3'd5, 3'd3, 3'd7, 3'd2, 3'd0, 3'd6, 3'd4};
    send(N, 2);
    chk_result("gap", 7, 3);
    step();

    // Reset mid-window discards the partial window
    w = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0};
    send(4, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_MAX", int'(bus.MAX), 0);
    chk("midrst_IDX", int'(bus.IDX), 0);
    chk("midrst_F_valid", int'(bus.F_valid), 0);
    #3 rst_n = 1'b1;
    step();
    w = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0};
    send(N, 0);
    chk_result("after_rst", 6, 5);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
